// File: rtl/ddr3_rd_checker.sv
// ddr3_rd_checker
//
// Purpose:
//   Checks a run of BEATS read beats coming back from a DDR3 memory
//   controller against a seeded incrementing pattern. Beat n is expected to
//   hold DATA_W/32 copies of (seed + n) mod 2^32. The checker counts
//   mismatching beats, remembers the first failing beat index, and reports
//   pass/fail with a one-cycle done pulse.
//
// Optional feature:
//   `define DDR3_CHK_TIMEOUT_EN compiles in an inter-beat watchdog. When
//   TMO_CYC cycles pass in CHECK without a valid beat, the run ends with
//   chk_timeout set and chk_pass cleared. Without the macro, chk_timeout is
//   tied low and a run waits indefinitely for its beats.
//
// Ports:
//   ui_clk            in   sole clock, rising edge
//   ui_rst            in   synchronous active-high reset
//   chk_start         in   one-cycle pulse that arms a run (ignored while busy)
//   chk_seed          in   32-bit pattern seed, latched on an accepted start
//   app_rd_data       in   DATA_W-bit read beat
//   app_rd_data_valid in   qualifies app_rd_data
//   chk_busy          out  high while a run is in progress
//   chk_done          out  one-cycle pulse at the end of a run
//   chk_pass          out  run result, valid with chk_done, held until next start
//   chk_timeout       out  sticky watchdog flag for the current run
//   error_num         out  mismatching beat count, saturates at 16'hFFFF
//   first_err_beat    out  index of first mismatching beat, 16'hFFFF if none

module ddr3_rd_checker #(
   parameter int BEATS   = 256,
   parameter int DATA_W  = 256,
   parameter int TMO_CYC = 1024
) (
   input  logic              ui_clk,
   input  logic              ui_rst,
   input  logic              chk_start,
   input  logic [31:0]       chk_seed,
   input  logic [DATA_W-1:0] app_rd_data,
   input  logic              app_rd_data_valid,
   output logic              chk_busy,
   output logic              chk_done,
   output logic              chk_pass,
   output logic              chk_timeout,
   output logic [15:0]       error_num,
   output logic [15:0]       first_err_beat
);

   localparam int          Words    = DATA_W / 32;
   localparam logic [15:0] LastBeat = 16'(BEATS - 1);
   localparam logic [15:0] NoError  = 16'hFFFF;

   typedef enum logic [1:0] {
      IDLE,
      CHECK,
      DONE
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] seed_q, seed_d;
   logic [15:0] beat_q, beat_d;
   logic [15:0] errorNum_q, errorNum_d;
   logic [15:0] firstErr_q, firstErr_d;
   logic        pass_q, pass_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;

   logic [31:0]       expWord;
   logic [DATA_W-1:0] expBeat;
   logic              beatMismatch;

`ifdef DDR3_CHK_TIMEOUT_EN
   localparam int TmoW = $clog2(TMO_CYC + 1);

   logic            tmo_q, tmo_d;
   logic [TmoW-1:0] idle_q, idle_d;
`else
   // TMO_CYC only matters when the watchdog is compiled in.
   if (TMO_CYC < 1) begin : gTmoCycUnused
   end
`endif

   // The beat index is zero-extended before the add so the pattern wraps
   // naturally at 2^32 regardless of the 16-bit counter.
   always_comb begin
      expWord      = seed_q + {16'h0000, beat_q};
      expBeat      = {Words{expWord}};
      beatMismatch = (app_rd_data != expBeat);
   end

   // Next-state logic for the whole checker. Valid beats are only consumed
   // in CHECK, and the transition to DONE happens on the edge that samples
   // the final beat, so nothing beyond BEATS is ever compared. The pass flag
   // is resolved from the post-update error count so it lines up with done.
   always_comb begin
      state_d    = state_q;
      seed_d     = seed_q;
      beat_d     = beat_q;
      errorNum_d = errorNum_q;
      firstErr_d = firstErr_q;
      pass_d     = pass_q;
`ifdef DDR3_CHK_TIMEOUT_EN
      tmo_d      = tmo_q;
      idle_d     = idle_q;
`endif

      case (state_q)
         IDLE: begin
            if (chk_start) begin
               state_d    = CHECK;
               seed_d     = chk_seed;
               beat_d     = 16'h0000;
               errorNum_d = 16'h0000;
               firstErr_d = NoError;
               pass_d     = 1'b0;
`ifdef DDR3_CHK_TIMEOUT_EN
               tmo_d      = 1'b0;
               idle_d     = '0;
`endif
            end
         end

         CHECK: begin
            if (app_rd_data_valid) begin
               beat_d = beat_q + 16'd1;
               if (beatMismatch) begin
                  if (errorNum_q != 16'hFFFF) begin
                     errorNum_d = errorNum_q + 16'd1;
                  end
                  if (firstErr_q == NoError) begin
                     firstErr_d = beat_q;
                  end
               end
`ifdef DDR3_CHK_TIMEOUT_EN
               idle_d = '0;
`endif
               if (beat_q == LastBeat) begin
                  state_d = DONE;
               end
            end
`ifdef DDR3_CHK_TIMEOUT_EN
            else begin
               idle_d = idle_q + 1'b1;
               if (idle_q == TmoW'(TMO_CYC - 1)) begin
                  tmo_d   = 1'b1;
                  state_d = DONE;
               end
            end
`endif
            if (state_d == DONE) begin
`ifdef DDR3_CHK_TIMEOUT_EN
               pass_d = (errorNum_d == 16'h0000) && !tmo_d;
`else
               pass_d = (errorNum_d == 16'h0000);
`endif
            end
         end

         DONE: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d == CHECK);
      done_d = (state_d == DONE);
   end

   // State and result registers; reset wins over a coincident start.
   always_ff @(posedge ui_clk) begin
      if (ui_rst) begin
         state_q    <= IDLE;
         seed_q     <= 32'h0000_0000;
         beat_q     <= 16'h0000;
         errorNum_q <= 16'h0000;
         firstErr_q <= NoError;
         pass_q     <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
`ifdef DDR3_CHK_TIMEOUT_EN
         tmo_q      <= 1'b0;
         idle_q     <= '0;
`endif
      end else begin
         state_q    <= state_d;
         seed_q     <= seed_d;
         beat_q     <= beat_d;
         errorNum_q <= errorNum_d;
         firstErr_q <= firstErr_d;
         pass_q     <= pass_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
`ifdef DDR3_CHK_TIMEOUT_EN
         tmo_q      <= tmo_d;
         idle_q     <= idle_d;
`endif
      end
   end

   assign chk_busy       = busy_q;
   assign chk_done       = done_q;
   assign chk_pass       = pass_q;
   assign error_num      = errorNum_q;
   assign first_err_beat = firstErr_q;
`ifdef DDR3_CHK_TIMEOUT_EN
   assign chk_timeout    = tmo_q;
`else
   assign chk_timeout    = 1'b0;
`endif

endmodule

// File: doc/ddr3_rd_checker.md
DDR3_RD_CHECKER -- requirements
Module: ddr3_rd_checker

Interface
REQ-001 Parameter BEATS, default 256, meaning number of read beats expected per check run (1..65535).
REQ-002 Parameter DATA_W, default 256, meaning app read data width, a multiple of 32.
REQ-003 Parameter TMO_CYC, default 1024, meaning maximum ui_clk cycles allowed between consecutive valid beats.
REQ-004 ui_clk  in  1  sole clock; all logic on its rising edge.
REQ-005 ui_rst  in  1  synchronous, active-high reset.
REQ-006 chk_start  in  1  one-cycle pulse that arms a run.
REQ-007 chk_seed  in  32  pattern seed, latched on an accepted chk_start.
REQ-008 app_rd_data  in  DATA_W  read beat from the memory controller.
REQ-009 app_rd_data_valid  in  1  qualifies app_rd_data.
REQ-010 chk_busy  out  1  high from the cycle after an accepted start until done.
REQ-011 chk_done  out  1  one-cycle pulse at run end.
REQ-012 chk_pass  out  1  valid with chk_done and held until next start; 1 = zero errors and no timeout.
REQ-013 chk_timeout  out  1  sticky timeout flag for the current run.
REQ-014 error_num  out  16  count of mismatching beats, saturating at 16'hFFFF.
REQ-015 first_err_beat  out  16  index of first mismatching beat; 16'hFFFF if none.

Function
REQ-016 States: IDLE, CHECK, DONE; reset state IDLE.
REQ-017 IDLE -> CHECK when chk_start=1; latch chk_seed; clear beat counter, error_num, chk_timeout, chk_pass; set first_err_beat=16'hFFFF.
REQ-018 chk_start while in CHECK or DONE is ignored.
REQ-019 Expected data for beat n = DATA_W/32 replicated copies of (seed + n) mod 2^32.
REQ-020 In CHECK, each cycle with app_rd_data_valid=1 compares the beat against the expected value and increments the beat counter by 1.
REQ-021 Mismatch on any bit -> error_num +1 (saturating at FFFF, no wrap); first_err_beat loaded with n only if still FFFF.
REQ-022 Comparison and counter update are registered; error_num reflects beat n one cycle after it is sampled.
REQ-023 app_rd_data_valid in IDLE or DONE is ignored; no counter changes.
REQ-024 CHECK -> DONE in the cycle after beat BEATS-1 is sampled; beats beyond BEATS are never accepted.
REQ-025 DONE lasts exactly one cycle: chk_done=1, chk_pass=(error_num==0 && !chk_timeout); then -> IDLE.
REQ-026 chk_busy=1 exactly while in CHECK.
REQ-027 Beat counter is 16 bits; beat index passed to the pattern is zero-extended to 32 bits before the add.

Reset
REQ-028 ui_rst=1 at any clock edge, including mid-run, forces IDLE with chk_busy=0, chk_done=0, chk_pass=0, chk_timeout=0, error_num=0, first_err_beat=16'hFFFF, seed=0, counters=0.
REQ-029 chk_start coincident with ui_rst is discarded.

Configuration
REQ-030 Macro DDR3_CHK_TIMEOUT_EN compiles the inter-beat watchdog in.
REQ-031 Defined: idle counter clears on each valid beat and on entry to CHECK, increments otherwise in CHECK; reaching TMO_CYC sets chk_timeout and goes CHECK -> DONE (chk_pass=0).
REQ-032 Undefined: no watchdog logic; chk_timeout tied 0; CHECK waits indefinitely for BEATS beats.

Verification
REQ-033 Reset, start with seed 32'h0000_1000, 256 beats matching the pattern back-to-back -> chk_done one cycle after last beat, chk_pass=1, error_num=0, first_err_beat=FFFF.
REQ-034 Same run with beat 5 bit 0 flipped and beat 200 all-zero -> error_num=2, first_err_beat=5, chk_pass=0.
REQ-035 Valid beats gapped by random 0..20 idle cycles, seed 32'hFFFF_FFFE -> pattern wraps at beat 2 (expected word 0), chk_pass=1.
REQ-036 With DDR3_CHK_TIMEOUT_EN, TMO_CYC=1024: stop after beat 99 -> chk_timeout=1 and chk_done 1024 cycles after last beat, chk_pass=0, error_num=0.
REQ-037 ui_rst asserted after beat 50 with 3 errors logged -> next cycle IDLE, error_num=0, chk_busy=0; new start runs a clean pass.
REQ-038 BEATS=70000-beat equivalent via BEATS=65535 all-mismatch -> error_num saturates at FFFF, no wrap; chk_start pulsed mid-run has no effect.
